ssd1306_spi_stream: RTL
=======================

// Module: ssd1306_spi_stream
// PURPOSE
// Parametrised 4-wire SPI driver for SSD1306-class OLED panels; successor to the fixed-size driver under the OLED top.
// Sequences hardware reset, sends the init command list, then streams full frames from an upstream byte source (valid/ready).
// Adds configurable SCLK rate, panel geometry, per-frame address window and a runtime invert mode.
// Sits between a framebuffer/renderer and the OLED pins (d0=sclk, d1=sdin, res, dc, cs).
// PARAMETERS
// CLK_DIV         4      SCLK half-period in clk cycles (>=1); byte slot = 17*CLK_DIV cycles
// RES_LOW_CYCLES  27000  cycles res held low after reset (1 ms @ 27 MHz)
// RES_WAIT_CYCLES 27000  cycles after res rises before first init byte
// COLS            128    panel columns (1..128)
// PAGES           8      panel pages of 8 rows (1..8); frame = COLS*PAGES bytes
// PORTS
// clk         in   1  system clock (27 MHz)
// reset       in   1  synchronous, active-high reset
// pix_data    in   8  frame byte (page-major, column-minor; bit0 = top row of page)
// pix_valid   in   1  pix_data valid
// pix_ready   out  1  byte accepted when pix_valid & pix_ready
// invert      in   1  1 = inverted display; sampled at frame start
// sclk        out  1  SPI clock, idle low
// sdin        out  1  SPI data, MSB first
// res         out  1  panel reset, active low
// dc          out  1  0 = command byte, 1 = pixel data byte
// cs          out  1  chip select, active low
// init_done   out  1  high once init list sent; stays high until reset
// frame_done  out  1  one-cycle pulse after last byte of a frame
// busy        out  1  high whenever state != IDLE
// BEHAVIOUR
// - Reset values: sclk 0, sdin 0, res 0, dc 0, cs 1, pix_ready 0, init_done 0, frame_done 0, busy 1; byte/frame counters 0; invert_q 0.
// - reset asserted at any time (incl. mid-byte/mid-frame): outputs take reset values next cycle, FSM -> RES_LOW, partial frame discarded.
// - FSM: RES_LOW (res=0, RES_LOW_CYCLES) -> RES_WAIT (res=1, RES_WAIT_CYCLES) -> INIT -> IDLE -> [INV] -> WIN -> DATA -> IDLE.
// - INIT: dc=0 bytes AE D5 80 A8 (PAGES*8-1) D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF (25 bytes); then init_done=1.
// - IDLE: frame starts on the cycle pix_valid=1 (no byte consumed yet). If invert != invert_q: INV sends A6|invert (dc=0), updates invert_q.
// - WIN: dc=0 bytes 21 00 (COLS-1) 22 00 (PAGES-1).
// - DATA: pix_ready=1 only when shifter idle and gap elapsed; handshake loads shifter, pix_ready drops next cycle; dc=1.
// - Stall: pix_valid=0 in DATA -> cs stays 1, sclk 0, no timeout; resumes on next valid.
// - After byte COLS*PAGES completes (cs rises): frame_done=1 for one cycle, counter wraps to 0, FSM -> IDLE.
// - Byte serialiser: cycle 0 cs=0, dc set, sdin=bit7, sclk=0; each bit = CLK_DIV cycles sclk low then CLK_DIV cycles sclk high;
//   sdin changes only on sclk falling (stable >= CLK_DIV cycles before rising); after 8th high phase sclk=0 and cs=1 same cycle;
//   cs held 1 for CLK_DIV cycles before next byte. dc constant while cs=0.
// - Counters sized $clog2(max count+1); no overflow possible within legal parameter ranges.
// TESTING (CLK_DIV=2, RES_LOW_CYCLES=10, RES_WAIT_CYCLES=10, COLS=4, PAGES=2)
// - Release reset -> res=0 for 10 cycles, 1 after; first decoded byte AE with dc=0; 25 bytes match list (5th=0x0F); init_done rises after 25th.
// - pix_valid held with bytes 01..08 -> bus shows 21 00 03 22 00 01 (dc=0) then 01..08 (dc=1); frame_done single pulse after 08; busy 0 after.
// - Drop pix_valid after 3rd data byte for 50 cycles -> cs=1, sclk=0, no edges; bytes 04..08 follow on resume; exactly 8 handshakes.
// - invert=1 before 2nd frame -> A7 (dc=0) precedes window bytes; 3rd frame with invert unchanged -> no A6/A7 sent.
// - Assert reset during 5th data byte mid-bit -> next cycle cs=1, sclk=0, res=0, init_done=0; full init replays; next frame starts at byte 0.
// - Timing check on any byte: 8 sclk rising edges, each high 2 cycles, sdin stable 2 cycles before each rise, MSB first, 34-cycle slot.

Source files
------------

// File: rtl/ssd1306_spi_stream.sv
// 4-wire SPI driver for SSD1306-class OLED panels: hardware reset, init command list,
// then full-frame streaming from a valid/ready byte source with per-frame window and invert.
module ssd1306_spi_stream #(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned RES_LOW_CYCLES  = 27000,
    parameter int unsigned RES_WAIT_CYCLES = 27000,
    parameter int unsigned COLS            = 128,
    parameter int unsigned PAGES           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic       invert,
    output logic       sclk,
    output logic       sdin,
    output logic       res,
    output logic       dc,
    output logic       cs,
    output logic       init_done,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned FRAME_BYTES = COLS * PAGES;
    localparam int unsigned TMR_MAX     = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
    localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);
    localparam int unsigned DIV_W       = $clog2(CLK_DIV + 1);
    localparam int unsigned FB_W        = $clog2(FRAME_BYTES + 1);
    localparam int unsigned INIT_LEN    = 25;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] RES_LOW_T  = TMR_W'(RES_LOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] RES_WAIT_T = TMR_W'(RES_WAIT_CYCLES - 1);
    localparam logic [FB_W-1:0]  FB_LAST    = FB_W'(FRAME_BYTES);
    localparam logic [4:0]       INIT_END   = 5'(INIT_LEN);

    typedef enum logic [2:0] {
        S_RES_LOW,
        S_RES_WAIT,
        S_INIT,
        S_IDLE,
        S_INV,
        S_WIN,
        S_DATA
    } state_t;

    function automatic logic [7:0] init_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = 8'hAE;
            5'd1:    b = 8'hD5;
            5'd2:    b = 8'h80;
            5'd3:    b = 8'hA8;
            5'd4:    b = 8'(PAGES * 8 - 1);
            5'd5:    b = 8'hD3;
            5'd6:    b = 8'h00;
            5'd7:    b = 8'h40;
            5'd8:    b = 8'h8D;
            5'd9:    b = 8'h14;
            5'd10:   b = 8'h20;
            5'd11:   b = 8'h00;
            5'd12:   b = 8'hA1;
            5'd13:   b = 8'hC8;
            5'd14:   b = 8'hDA;
            5'd15:   b = 8'h12;
            5'd16:   b = 8'h81;
            5'd17:   b = 8'hCF;
            5'd18:   b = 8'hD9;
            5'd19:   b = 8'hF1;
            5'd20:   b = 8'hDB;
            5'd21:   b = 8'h40;
            5'd22:   b = 8'hA4;
            5'd23:   b = 8'hA6;
            5'd24:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] win_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h21;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'(COLS - 1);
            3'd3:    b = 8'h22;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'(PAGES - 1);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Control FSM state
    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [4:0]       cmd_idx_q, cmd_idx_d;
    logic [FB_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic             invert_q, invert_d;
    logic             res_q, res_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;

    // Serialiser state
    logic             active_q, active_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       half_q, half_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [DIV_W-1:0] gap_q, gap_d;
    logic             sclk_q, sclk_d;
    logic             sdin_q, sdin_d;
    logic             cs_q, cs_d;
    logic             dc_q, dc_d;

    logic             ser_ready;
    logic             ser_end;
    logic             load;
    logic [7:0]       load_byte;
    logic             load_dc;

    assign ser_ready = !active_q && (gap_q == '0);
    assign ser_end   = active_q && (div_q == DIV_LAST) && (half_q == 4'd15);

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        cmd_idx_d    = cmd_idx_q;
        byte_cnt_d   = byte_cnt_q;
        invert_d     = invert_q;
        res_d        = res_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        load         = 1'b0;
        load_byte    = '0;
        load_dc      = 1'b0;

        case (state_q)
            S_RES_LOW: begin
                res_d = 1'b0;
                if (tmr_q == RES_LOW_T) begin
                    tmr_d   = '0;
                    res_d   = 1'b1;
                    state_d = S_RES_WAIT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RES_WAIT: begin
                if (tmr_q == RES_WAIT_T) begin
                    tmr_d   = '0;
                    state_d = S_INIT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_INIT: begin
                if (cmd_idx_q != INIT_END) begin
                    if (ser_ready) begin
                        load      = 1'b1;
                        load_byte = init_byte(cmd_idx_q);
                        cmd_idx_d = cmd_idx_q + 1'b1;
                    end
                end else if (ser_end) begin
                    // init_done rises only once the final command has left the wire
                    init_done_d = 1'b1;
                    cmd_idx_d   = '0;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (pix_valid) begin
                    cmd_idx_d = '0;
                    if (invert != invert_q) begin
                        invert_d = invert;
                        state_d  = S_INV;
                    end else begin
                        state_d = S_WIN;
                    end
                end
            end
            S_INV: begin
                if (ser_ready) begin
                    load      = 1'b1;
                    load_byte = {7'b1010011, invert_q};
                    state_d   = S_WIN;
                end
            end
            S_WIN: begin
                if (ser_ready) begin
                    load      = 1'b1;
                    load_byte = win_byte(cmd_idx_q[2:0]);
                    if (cmd_idx_q == 5'd5) begin
                        cmd_idx_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (byte_cnt_q != FB_LAST) begin
                    if (pix_valid && pix_ready) begin
                        load       = 1'b1;
                        load_byte  = pix_data;
                        load_dc    = 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else if (ser_end) begin
                    byte_cnt_d   = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_RES_LOW;
        endcase
    end

    // Bit n is shifted onto sdin on the falling sclk that ends bit n+1's high phase
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        half_d   = half_q;
        shreg_d  = shreg_q;
        gap_d    = gap_q;
        sclk_d   = sclk_q;
        sdin_d   = sdin_q;
        cs_d     = cs_q;
        dc_d     = dc_q;

        if (load) begin
            active_d = 1'b1;
            div_d    = '0;
            half_d   = '0;
            shreg_d  = {load_byte[6:0], 1'b0};
            sdin_d   = load_byte[7];
            sclk_d   = 1'b0;
            cs_d     = 1'b0;
            dc_d     = load_dc;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (half_q == 4'd15) begin
                    active_d = 1'b0;
                    sclk_d   = 1'b0;
                    cs_d     = 1'b1;
                    gap_d    = DIV_LAST;
                end else begin
                    half_d = half_q + 1'b1;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        sdin_d  = shreg_q[7];
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RES_LOW;
            tmr_q        <= '0;
            cmd_idx_q    <= '0;
            byte_cnt_q   <= '0;
            invert_q     <= 1'b0;
            res_q        <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            active_q     <= 1'b0;
            div_q        <= '0;
            half_q       <= '0;
            shreg_q      <= '0;
            gap_q        <= '0;
            sclk_q       <= 1'b0;
            sdin_q       <= 1'b0;
            cs_q         <= 1'b1;
            dc_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            cmd_idx_q    <= cmd_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            invert_q     <= invert_d;
            res_q        <= res_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            active_q     <= active_d;
            div_q        <= div_d;
            half_q       <= half_d;
            shreg_q      <= shreg_d;
            gap_q        <= gap_d;
            sclk_q       <= sclk_d;
            sdin_q       <= sdin_d;
            cs_q         <= cs_d;
            dc_q         <= dc_d;
        end
    end

    assign pix_ready  = (state_q == S_DATA) && ser_ready && (byte_cnt_q != FB_LAST);
    assign busy       = (state_q != S_IDLE);
    assign sclk       = sclk_q;
    assign sdin       = sdin_q;
    assign res        = res_q;
    assign dc         = dc_q;
    assign cs         = cs_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule
